// File: rtl/reg_file_2r1w_if.sv
// reg_file_2r1w_if: write/read bus of the 2-read 1-write register file (master = requester, slave = register file)
interface reg_file_2r1w_if #(parameter int W = 8, parameter int AW = 3);
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic          re_a;
  logic [AW-1:0] raddr_a;
  logic [W-1:0]  rdata_a;
  logic          valid_a;
  logic          re_b;
  logic [AW-1:0] raddr_b;
  logic [W-1:0]  rdata_b;
  logic          valid_b;
  logic          err;
  modport master(output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
                 input rdata_a, valid_a, rdata_b, valid_b, err);
  modport slave(input we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
                output rdata_a, valid_a, rdata_b, valid_b, err);
endinterface

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 1 write / 2 registered read register file with write-first bypass; ports clk, rst (sync, active-high), bus (slave: we/waddr/wdata, re_x/raddr_x -> rdata_x/valid_x, err)
module reg_file_2r1w #(
  parameter int W        = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input logic clk,
  input logic rst,
  reg_file_2r1w_if.slave bus
);
  logic [W-1:0] mem [DEPTH];
  logic         w_ok;
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction
  function automatic logic [W-1:0] rd(input logic [AW-1:0] a);
    return (!in_range(a) || (ZERO_REG && a == '0)) ? '0 :
           (w_ok && bus.waddr == a) ? bus.wdata : mem[a];
  endfunction
  assign w_ok = bus.we && in_range(bus.waddr) && !(ZERO_REG && bus.waddr == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      bus.rdata_a <= '0;
      bus.rdata_b <= '0;
      bus.valid_a <= 1'b0;
      bus.valid_b <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      if (w_ok) mem[bus.waddr] <= bus.wdata;
      if (bus.re_a) bus.rdata_a <= rd(bus.raddr_a);
      if (bus.re_b) bus.rdata_b <= rd(bus.raddr_b);
      bus.valid_a <= bus.re_a;
      bus.valid_b <= bus.re_b;
      bus.err     <= (bus.we && !in_range(bus.waddr)) ||
                     (bus.re_a && !in_range(bus.raddr_a)) ||
                     (bus.re_b && !in_range(bus.raddr_b));
    end
  end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: scoreboard bench driving a default instance and a DEPTH=6/ZERO_REG=1 instance with identical stimulus
module tb_reg_file_2r1w;
  typedef struct packed {
    logic [7:0] ra;
    logic       va;
    logic [7:0] rb;
    logic       vb;
    logic       e;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] mem [2][8];
  logic [7:0] hra [2];
  logic [7:0] hrb [2];
  reg_file_2r1w_if #(.W(8), .AW(3)) if0 ();
  reg_file_2r1w_if #(.W(8), .AW(3)) if1 ();
  reg_file_2r1w #(.W(8), .DEPTH(8), .AW(3), .ZERO_REG(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  reg_file_2r1w #(.W(8), .DEPTH(6), .AW(3), .ZERO_REG(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  always #5 clk = ~clk;
  function automatic logic [7:0] model_read(input int i, input logic [2:0] a, input logic ok,
                                            input logic [2:0] wa, input logic [7:0] wd);
    int dep = (i == 1) ? 6 : 8;
    if (a >= dep) return 8'h00;
    if (i == 1 && a == 3'd0) return 8'h00;
    if (ok && wa == a) return wd;
    return mem[i][a];
  endfunction
  task automatic step(input logic r, input logic w, input logic [2:0] wa, input logic [7:0] wd,
                      input logic ea, input logic [2:0] aa, input logic eb, input logic [2:0] ab);
    @(negedge clk);
    rst = r;
    if0.we = w; if0.waddr = wa; if0.wdata = wd;
    if0.re_a = ea; if0.raddr_a = aa; if0.re_b = eb; if0.raddr_b = ab;
    if1.we = w; if1.waddr = wa; if1.wdata = wd;
    if1.re_a = ea; if1.raddr_a = aa; if1.re_b = eb; if1.raddr_b = ab;
    for (int i = 0; i < 2; i++) begin
      int   dep = (i == 1) ? 6 : 8;
      logic ok = w && (wa < dep) && !(i == 1 && wa == 3'd0);
      exp_t e;
      if (r) begin
        for (int k = 0; k < 8; k++) mem[i][k] = 8'h00;
        e = '0;
      end else begin
        e.ra = ea ? model_read(i, aa, ok, wa, wd) : hra[i];
        e.rb = eb ? model_read(i, ab, ok, wa, wd) : hrb[i];
        e.va = ea;
        e.vb = eb;
        e.e  = (w && wa >= dep) || (ea && aa >= dep) || (eb && ab >= dep);
        if (ok) mem[i][wa] = wd;
      end
      hra[i] = e.ra;
      hrb[i] = e.rb;
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask
  task automatic check(input string name, input exp_t exp, input exp_t act);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got ra=%h va=%b rb=%h vb=%b err=%b, want ra=%h va=%b rb=%h vb=%b err=%b",
               name, act.ra, act.va, act.rb, act.vb, act.e, exp.ra, exp.va, exp.rb, exp.vb, exp.e);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) check("u0", q0.pop_front(), {if0.rdata_a, if0.valid_a, if0.rdata_b, if0.valid_b, if0.err});
    if (q1.size() > 0) check("u1", q1.pop_front(), {if1.rdata_a, if1.valid_a, if1.rdata_b, if1.valid_b, if1.err});
  end
  initial begin
    {if0.we, if0.waddr, if0.wdata, if0.re_a, if0.raddr_a, if0.re_b, if0.raddr_b} = '0;
    {if1.we, if1.waddr, if1.wdata, if1.re_a, if1.raddr_a, if1.re_b, if1.raddr_b} = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 8'h5A, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 8'h11, 0, 0, 0, 0);
    step(0, 1, 5, 8'hC3, 1, 5, 1, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 0, 0);
    step(0, 1, 1, 8'h01, 0, 0, 0, 0);
    step(0, 1, 2, 8'h02, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 2);
    step(0, 0, 0, 0, 1, 2, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 8'hFF, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 7, 8'h77, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 1, 5);
    step(0, 0, 0, 0, 1, 6, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, 3'(k), 8'(8'hA0 + k), 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4, 1, 1);
    step(1, 1, 2, 8'h99, 1, 2, 1, 3);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1, 3'(k), 1, 3'(7 - k));
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 39) == 0, 1'($urandom), 3'($urandom), 8'($urandom),
           1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
    step(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got pending=%0d, want pending=0", q0.size() + q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Register file for the 8-bit CPU datapath: one write port, two independent synchronous read ports (A and B).
- The ALU operand fetch and the bus read-back path read architectural registers through this block; the execute stage writes results into it.
- Reads are registered with 1-cycle latency and a per-port valid strobe.
- A same-cycle write/read bypass returns the value being written.

Parameters:
- W, 8, data width in bits
- DEPTH, 8, number of implemented registers (1 to 2^AW)
- AW, 3, address width
- ZERO_REG, 0, if 1, register 0 is hard-wired to zero: writes to it are ignored and reads of it return 0

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- we  input  1  write enable
- waddr  input  AW  write address
- wdata  input  W  write data
- re_a  input  1  port A read request
- raddr_a  input  AW  port A read address
- rdata_a  output  W  port A read data, registered
- valid_a  output  1  port A data valid, one-cycle pulse
- re_b  input  1  port B read request
- raddr_b  input  AW  port B read address
- rdata_b  output  W  port B read data, registered
- valid_b  output  1  port B data valid, one-cycle pulse
- err  output  1  address error, one-cycle pulse

Behaviour:
- Reset: when rst=1 at a rising edge:
  - all DEPTH entries are cleared to 0
  - rdata_a, rdata_b = 0; valid_a, valid_b, err = 0
  - rst has priority over we, re_a and re_b in the same cycle; a write or read presented with rst is discarded
- Write:
  - on a rising edge with we=1 and waddr < DEPTH, the entry at waddr takes wdata
  - exception: if ZERO_REG=1 and waddr=0, the write is dropped silently and err is not raised
- Read latency:
  - re_x=1 at edge N gives rdata_x and valid_x=1 after edge N
  - valid_x returns to 0 after edge N+1 unless re_x is asserted again
  - re_x held high gives back-to-back reads, one per cycle, with valid_x held at 1
- Hold: when re_x=0, rdata_x holds its last value; it is not cleared and does not track storage.
- Bypass (write-first):
  - if we=1 and re_x=1 in the same cycle with raddr_x == waddr, and the write is legal, rdata_x = wdata
  - this applies to both ports simultaneously
  - if the write is dropped because of ZERO_REG, the read returns 0
- Port independence:
  - A and B may read the same or different addresses in the same cycle with no stall
  - neither port has priority over the other
- Out-of-range (only possible when DEPTH < 2^AW): an address >= DEPTH is out of range.
  - Write to an out-of-range address: the write is ignored, no storage changes, and err=1 the next cycle.
  - Read of an out-of-range address: rdata_x = 0, valid_x = 1 (the read still completes), and err=1 the next cycle.
  - err is the OR of all error sources in that cycle, as a single pulse.
  - Bypass never applies to an out-of-range address.
- Zero register (ZERO_REG=1): a read of address 0 always returns 0 regardless of the write history.
- Reset mid-operation: when rst=1 at the edge immediately after a read request, the valid pulse is suppressed and rdata=0.
- No combinational path from any input to any output. All outputs come from flops.

Test Plan:
- Reset, write 0x5A to reg 3, then re_a with raddr_a=3 -> next cycle rdata_a=0x5A, valid_a=1; the cycle after, valid_a=0 and rdata_a stays 0x5A.
- Same cycle: we=1, waddr=5, wdata=0xC3, re_a=1, raddr_a=5, re_b=1, raddr_b=5, with reg 5 previously 0x11 -> rdata_a=rdata_b=0xC3 (bypass); a later read of reg 5 returns 0xC3.
- Write reg 1=0x01 and reg 2=0x02, then read A=1 and B=2 in one cycle, then A=2 and B=1 back-to-back -> correct swapped values on consecutive cycles; valid_a and valid_b stay 1 across both cycles.
- ZERO_REG=1: write 0xFF to reg 0 together with a same-cycle read of reg 0 -> rdata=0x00, err=0; a later read of reg 0 also returns 0x00.
- DEPTH=6, AW=3:
  - write 0x77 to addr 7 -> err pulses for exactly 1 cycle and no entry changes
  - read of addr 6 -> rdata=0x00, valid=1, err=1
- Fill all entries with non-zero values, assert rst for 1 cycle together with a read request -> valid stays 0, rdata=0, and every subsequent read returns 0x00.
